// File: rtl/layer_sequencer_pkg.sv
// neural_pkg: shared FSM states and descriptor type for the layer sequencer
package neural_pkg;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DRAIN,
        WRITE,
        NEXT_LAYER,
        DONE
    } state_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] in_cnt;
        logic [DEF_ADDR_W-1:0] out_cnt;
    } desc_t;
endpackage

// File: rtl/layer_sequencer_if.sv
// layer_sequencer_if: host/config handshake plus datapath control bundle
interface layer_sequencer_if
    import neural_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LIDX_W = 2
);
    logic              cfg_we;
    logic [LIDX_W-1:0] cfg_idx;
    logic [ADDR_W-1:0] cfg_in_cnt;
    logic [ADDR_W-1:0] cfg_out_cnt;
    logic [LIDX_W:0]   num_layers;
    logic              start;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] neuro_read_addr;
    logic [ADDR_W-1:0] weight_read_addr;
    logic [ADDR_W-1:0] neuro_write_addr;
    logic              wr_en;
    logic              mac_clear;
    logic              mac_en;

    modport master (
        output cfg_we, cfg_idx, cfg_in_cnt, cfg_out_cnt, num_layers, start,
        input  busy, done, err, neuro_read_addr, weight_read_addr, neuro_write_addr,
        input  wr_en, mac_clear, mac_en
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_in_cnt, cfg_out_cnt, num_layers, start,
        output busy, done, err, neuro_read_addr, weight_read_addr, neuro_write_addr,
        output wr_en, mac_clear, mac_en
    );
endinterface

// File: rtl/layer_sequencer_desc_table.sv
// layer_desc_table: per-layer descriptor register file with combinational schedule validation
module layer_desc_table
    import neural_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int MAX_LAYERS = 4,
    parameter int LIDX_W     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [LIDX_W-1:0] widx,
    input  logic [ADDR_W-1:0] w_in,
    input  logic [ADDR_W-1:0] w_out,
    input  logic [LIDX_W-1:0] ridx,
    input  logic [LIDX_W:0]   num_layers,
    output desc_t             rdesc,
    output logic              cfg_err
);
    localparam int NW = LIDX_W + 1;
    localparam int SW = 2 * ADDR_W + LIDX_W + 1;
    localparam logic [SW-1:0] LIM = SW'(1) << ADDR_W;

    desc_t tbl [MAX_LAYERS];
    logic [SW-1:0] wsum, isum, fin;
    logic bad;

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            for (int k = 0; k < MAX_LAYERS; k++) tbl[k] <= '0;
        else if (we)
            tbl[widx] <= '{in_cnt: w_in, out_cnt: w_out};

    assign rdesc = tbl[ridx];

    // fin ends up as the last used layer's output base plus its out_cnt
    always_comb begin
        wsum = '0;
        isum = '0;
        fin = '0;
        bad = num_layers == '0 || num_layers > NW'(MAX_LAYERS);
        for (int k = 0; k < MAX_LAYERS; k++)
            if (NW'(k) < num_layers) begin
                bad = bad || tbl[k].in_cnt == '0 || tbl[k].out_cnt == '0;
                wsum = wsum + SW'(tbl[k].in_cnt) * SW'(tbl[k].out_cnt);
                isum = isum + SW'(tbl[k].in_cnt);
                fin = isum + SW'(tbl[k].out_cnt);
            end
        cfg_err = bad || wsum > LIM || fin > LIM;
    end
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: layer-by-layer MAC schedule driving neuron RAM, weight ROM and MAC core
module layer_sequencer
    import neural_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int MAX_LAYERS = 4,
    parameter int LIDX_W     = 2
) (
    input logic clk,
    input logic reset,
    layer_sequencer_if.slave bus
);
    state_t state, nxt;
    desc_t cur;
    logic cfg_err, mac_en_q, err_q, last_in, last_out, last_layer;
    logic [LIDX_W-1:0] lay;
    logic [LIDX_W:0] nl;
    logic [ADDR_W-1:0] i, n, in_base, w_ptr, ra_hold, wa_hold, wr_hold, out_addr;

    layer_desc_table #(
        .ADDR_W(ADDR_W),
        .MAX_LAYERS(MAX_LAYERS),
        .LIDX_W(LIDX_W)
    ) u_table (
        .clk(clk),
        .reset(reset),
        .we(bus.cfg_we && state == IDLE),
        .widx(bus.cfg_idx),
        .w_in(bus.cfg_in_cnt),
        .w_out(bus.cfg_out_cnt),
        .ridx(lay),
        .num_layers(bus.num_layers),
        .rdesc(cur),
        .cfg_err(cfg_err)
    );

    assign last_in = i == cur.in_cnt - 1'b1;
    assign last_out = n == cur.out_cnt - 1'b1;
    assign last_layer = {1'b0, lay} + 1'b1 == nl;
    assign out_addr = in_base + cur.in_cnt + n;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:       nxt = bus.start ? (cfg_err ? DONE : CLEAR) : IDLE;
            CLEAR:      nxt = ACCUM;
            ACCUM:      nxt = last_in ? DRAIN : ACCUM;
            DRAIN:      nxt = WRITE;
            WRITE:      nxt = last_out ? NEXT_LAYER : CLEAR;
            NEXT_LAYER: nxt = last_layer ? DONE : CLEAR;
            default:    nxt = IDLE;
        endcase
        bus.busy = !(state inside {IDLE, DONE});
        bus.done = state == DONE;
        bus.err = err_q;
        bus.mac_clear = state == CLEAR;
        bus.wr_en = state == WRITE;
        bus.mac_en = mac_en_q;
        bus.neuro_read_addr = state == ACCUM ? in_base + i : ra_hold;
        bus.weight_read_addr = state == ACCUM ? w_ptr : wa_hold;
        bus.neuro_write_addr = state == WRITE ? out_addr : wr_hold;
    end

    // hold registers keep the address buses steady outside their active state
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            lay <= '0;
            nl <= '0;
            i <= '0;
            n <= '0;
            in_base <= '0;
            w_ptr <= '0;
            ra_hold <= '0;
            wa_hold <= '0;
            wr_hold <= '0;
            err_q <= 1'b0;
            mac_en_q <= 1'b0;
        end else begin
            mac_en_q <= state == ACCUM;
            if (state == IDLE && bus.start) begin
                err_q <= cfg_err;
                nl <= bus.num_layers;
                lay <= '0;
                in_base <= '0;
                w_ptr <= '0;
                n <= '0;
            end
            if (state == CLEAR) i <= '0;
            if (state == ACCUM) begin
                i <= i + 1'b1;
                w_ptr <= w_ptr + 1'b1;
                ra_hold <= in_base + i;
                wa_hold <= w_ptr;
            end
            if (state == WRITE) begin
                n <= n + 1'b1;
                wr_hold <= out_addr;
            end
            if (state == NEXT_LAYER) begin
                lay <= lay + 1'b1;
                in_base <= in_base + cur.in_cnt;
                n <= '0;
            end
        end
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed and randomized schedules checked against a flat-loop reference model
module tb_layer_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    int m_in [4];
    int m_out [4];

    always #5 clk = ~clk;

    layer_sequencer_if #(.ADDR_W(8), .LIDX_W(2)) bus ();
    layer_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic cfg(input int idx, input int ic, input int oc);
        @(negedge clk);
        bus.cfg_we = 1'b1;
        bus.cfg_idx = 2'(idx);
        bus.cfg_in_cnt = 8'(ic);
        bus.cfg_out_cnt = 8'(oc);
        @(negedge clk);
        bus.cfg_we = 1'b0;
        m_in[idx] = ic;
        m_out[idx] = oc;
    endtask

    task automatic run(input string tag, input int nl, input bit poke);
        int rd_a[$], rd_w[$], wr_a[$], ob_ra[$], ob_rw[$], ob_wr[$];
        int base = 0, w = 0, busy_exp = 0, wsum = 0, isum = 0, fin = 0;
        int busy_cnt = 0, clears = 0, dones = 0, done_k = 0;
        int h_ra = 0, h_wa = 0, h_wr = 0, prev_ra = 0, prev_wa = 0;
        bit bad, both = 0, err_at = 0, busy_at = 0;
        bad = nl < 1 || nl > 4;
        if (!bad)
            for (int l = 0; l < nl; l++) begin
                if (m_in[l] == 0 || m_out[l] == 0) bad = 1;
                wsum += m_in[l] * m_out[l];
                isum += m_in[l];
                fin = isum + m_out[l];
            end
        bad = bad || wsum > 256 || fin > 256;
        if (!bad)
            for (int l = 0; l < nl; l++) begin
                for (int o = 0; o < m_out[l]; o++) begin
                    for (int k = 0; k < m_in[l]; k++) begin
                        rd_a.push_back(base + k);
                        rd_w.push_back(w++);
                    end
                    wr_a.push_back(base + m_in[l] + o);
                end
                base += m_in[l];
                busy_exp += m_out[l] * (m_in[l] + 3) + 1;
            end
        @(negedge clk);
        bus.num_layers = 3'(nl);
        bus.start = 1'b1;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (poke && k == 5) begin
                bus.start = 1'b1;
                bus.cfg_we = 1'b1;
                bus.cfg_idx = 2'd0;
                bus.cfg_in_cnt = 8'd9;
                bus.cfg_out_cnt = 8'd9;
            end else if (poke && k == 6) begin
                bus.start = 1'b0;
                bus.cfg_we = 1'b0;
            end
            if (bus.mac_en) begin
                ob_ra.push_back(prev_ra);
                ob_rw.push_back(prev_wa);
            end
            if (bus.wr_en) ob_wr.push_back(int'(bus.neuro_write_addr));
            busy_cnt += int'(bus.busy);
            clears += int'(bus.mac_clear);
            both |= bus.wr_en && bus.mac_clear;
            if (bus.done) begin
                dones++;
                if (done_k == 0) begin
                    done_k = k;
                    err_at = bus.err;
                    busy_at = bus.busy;
                    h_ra = int'(bus.neuro_read_addr);
                    h_wa = int'(bus.weight_read_addr);
                    h_wr = int'(bus.neuro_write_addr);
                end
            end
            prev_ra = int'(bus.neuro_read_addr);
            prev_wa = int'(bus.weight_read_addr);
            if (done_k != 0 && k >= done_k + 4) break;
        end
        chk({tag, ".done_at"}, done_k, busy_exp + 1);
        chk({tag, ".dones"}, dones, 1);
        chk({tag, ".err"}, err_at, bad);
        chk({tag, ".busy_at_done"}, busy_at, 0);
        chk({tag, ".busy_cycles"}, busy_cnt, busy_exp);
        chk({tag, ".clears"}, clears, wr_a.size());
        chk({tag, ".clear_wr_overlap"}, both, 0);
        chk({tag, ".n_reads"}, ob_ra.size(), rd_a.size());
        for (int k = 0; k < rd_a.size() && k < ob_ra.size(); k++) begin
            chk($sformatf("%s.rd_addr%0d", tag, k), ob_ra[k], rd_a[k]);
            chk($sformatf("%s.w_addr%0d", tag, k), ob_rw[k], rd_w[k]);
        end
        chk({tag, ".n_writes"}, ob_wr.size(), wr_a.size());
        for (int k = 0; k < wr_a.size() && k < ob_wr.size(); k++)
            chk($sformatf("%s.wr_addr%0d", tag, k), ob_wr[k], wr_a[k]);
        if (!bad) begin
            chk({tag, ".held_rd"}, h_ra, rd_a[rd_a.size() - 1]);
            chk({tag, ".held_w"}, h_wa, rd_w[rd_w.size() - 1]);
            chk({tag, ".held_wr"}, h_wr, wr_a[wr_a.size() - 1]);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"}, bus.busy, 0);
        chk({tag, ".outs"}, {bus.done, bus.err, bus.wr_en, bus.mac_clear, bus.mac_en,
            bus.neuro_read_addr, bus.weight_read_addr, bus.neuro_write_addr}, 0);
    endtask

    initial begin
        int nl;
        bus.cfg_we = 1'b0;
        bus.cfg_idx = '0;
        bus.cfg_in_cnt = '0;
        bus.cfg_out_cnt = '0;
        bus.num_layers = '0;
        bus.start = 1'b0;
        for (int l = 0; l < 4; l++) begin
            m_in[l] = 0;
            m_out[l] = 0;
        end
        repeat (3) @(negedge clk);
        chk_idle("in_reset");
        reset = 1'b1;
        @(negedge clk);
        chk_idle("after_reset");

        cfg(0, 3, 2);
        run("one_layer", 1, 0);
        cfg(0, 4, 2);
        cfg(1, 2, 1);
        run("two_layer", 2, 0);
        cfg(1, 2, 0);
        run("out_zero", 2, 0);
        cfg(1, 2, 1);
        run("busy_poke", 2, 1);
        run("after_poke", 2, 0);
        cfg(0, 255, 2);
        run("w_overflow", 1, 0);
        cfg(0, 3, 2);
        run("err_clear", 1, 0);
        run("bad_nl", 0, 0);

        for (int t = 0; t < 6; t++) begin
            for (int l = 0; l < 4; l++) cfg(l, $urandom_range(1, 16), $urandom_range(1, 5));
            if ($urandom_range(0, 3) == 0) cfg($urandom_range(0, 3), $urandom_range(0, 1), 0);
            nl = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
            run($sformatf("rand%0d", t), nl, 0);
        end

        cfg(0, 4, 2);
        cfg(1, 2, 1);
        @(negedge clk);
        bus.num_layers = 3'd2;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 20 && !bus.mac_en; k++) @(negedge clk);
        chk("rst.mid_accum", bus.mac_en, 1);
        #2 reset = 1'b0;
        #1 chk_idle("rst.async");
        @(negedge clk);
        reset = 1'b1;
        for (int l = 0; l < 4; l++) begin
            m_in[l] = 0;
            m_out[l] = 0;
        end
        run("rst_nocfg", 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
